// File: rtl/mips_multicycle_ctrl_if.sv
// Control bus between the multicycle MIPS controller (master) and its datapath (slave).
interface mips_multicycle_ctrl_if;
    logic [5:0] Op;
    logic [5:0] Funct;
    logic       zero;
    logic [2:0] ALUcontrol;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] PCSrc;
    logic       PCEn;
    logic       IorD;
    logic       IRWrite;
    logic       MemWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       RegWrite;
    logic       illegal;

    modport master (
        input  Op, Funct, zero,
        output ALUcontrol, ALUSrcA, ALUSrcB, PCSrc, PCEn, IorD, IRWrite,
               MemWrite, RegDst, MemtoReg, RegWrite, illegal
    );

    modport slave (
        output Op, Funct, zero,
        input  ALUcontrol, ALUSrcA, ALUSrcB, PCSrc, PCEn, IorD, IRWrite,
               MemWrite, RegDst, MemtoReg, RegWrite, illegal
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS Moore controller with ALU decoder.
// Optional feature: define MULTICYCLE_ADDI_EN to add the addi states (ADDIEX/ADDIWB).
module mips_multicycle_ctrl (
    input  logic                   clk,
    input  logic                   reset_n,
    mips_multicycle_ctrl_if.master bus
);
    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
`ifdef MULTICYCLE_ADDI_EN
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
`endif
        JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t state;
    logic   op_ok;
    logic   bad_decode;
    logic   pc_write, branch, ir_write, mem_write, reg_write;

    function automatic logic funct_ok(input logic [5:0] f);
        case (f)
            6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] alu_dec(input logic [5:0] f);
        case (f)
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    always_comb begin
        case (bus.Op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J: op_ok = 1'b1;
`ifdef MULTICYCLE_ADDI_EN
            OP_ADDI: op_ok = 1'b1;
`endif
            default: op_ok = 1'b0;
        endcase
    end

    assign bad_decode = !op_ok || (bus.Op == OP_RTYPE && !funct_ok(bus.Funct));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= FETCH;
        end else begin
            case (state)
                FETCH:  state <= DECODE;
                DECODE: begin
                    if (bad_decode) state <= FETCH;
                    else begin
                        case (bus.Op)
                            OP_LW, OP_SW: state <= MEMADR;
                            OP_RTYPE:     state <= EXEC;
                            OP_BEQ:       state <= BRANCH;
`ifdef MULTICYCLE_ADDI_EN
                            OP_ADDI:      state <= ADDIEX;
`endif
                            OP_J:         state <= JUMP;
                            default:      state <= FETCH;
                        endcase
                    end
                end
                MEMADR: state <= (bus.Op == OP_SW) ? MEMWR : MEMRD;
                MEMRD:  state <= MEMWB;
                EXEC:   state <= ALUWB;
`ifdef MULTICYCLE_ADDI_EN
                ADDIEX: state <= ADDIWB;
`endif
                default: state <= FETCH;
            endcase
        end
    end

    always_comb begin
        bus.ALUcontrol = 3'b010;
        bus.ALUSrcA    = 1'b0;
        bus.ALUSrcB    = 2'b00;
        bus.PCSrc      = 2'b00;
        bus.IorD       = 1'b0;
        bus.RegDst     = 1'b0;
        bus.MemtoReg   = 1'b0;
        bus.illegal    = 1'b0;
        pc_write       = 1'b0;
        branch         = 1'b0;
        ir_write       = 1'b0;
        mem_write      = 1'b0;
        reg_write      = 1'b0;
        case (state)
            FETCH: begin
                ir_write    = 1'b1;
                bus.ALUSrcB = 2'b01;
                pc_write    = 1'b1;
            end
            DECODE: begin
                bus.ALUSrcB = 2'b11;
                bus.illegal = bad_decode;
            end
`ifdef MULTICYCLE_ADDI_EN
            MEMADR, ADDIEX: begin
`else
            MEMADR: begin
`endif
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
            end
            MEMRD: bus.IorD = 1'b1;
            MEMWR: begin
                bus.IorD  = 1'b1;
                mem_write = 1'b1;
            end
            MEMWB: begin
                reg_write    = 1'b1;
                bus.MemtoReg = 1'b1;
            end
            EXEC: begin
                bus.ALUSrcA    = 1'b1;
                bus.ALUcontrol = alu_dec(bus.Funct);
            end
            ALUWB: begin
                reg_write  = 1'b1;
                bus.RegDst = 1'b1;
            end
`ifdef MULTICYCLE_ADDI_EN
            ADDIWB: reg_write = 1'b1;
`endif
            BRANCH: begin
                bus.ALUSrcA    = 1'b1;
                bus.ALUcontrol = 3'b110;
                bus.PCSrc      = 2'b01;
                branch         = 1'b1;
            end
            JUMP: begin
                bus.PCSrc = 2'b10;
                pc_write  = 1'b1;
            end
            default: ;
        endcase
    end

    // Write enables are forced low for the whole reset window, independent of the clock.
    assign bus.PCEn     = reset_n & (pc_write | (branch & bus.zero));
    assign bus.IRWrite  = reset_n & ir_write;
    assign bus.MemWrite = reset_n & mem_write;
    assign bus.RegWrite = reset_n & reg_write;
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl; expected output vectors are queued per cycle.
module tb_mips_multicycle_ctrl;
    localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMRD = 3, S_MEMWB = 4,
                   S_MEMWR = 5, S_EXEC = 6, S_ALUWB = 7, S_BRANCH = 8, S_ADDIEX = 9,
                   S_ADDIWB = 10, S_JUMP = 11;

    logic clk = 1'b0;
    logic reset_n;
    int   errors = 0;
    int   checks = 0;
    logic [16:0] exp_q[$];
    logic [5:0]  op_q[$];
    logic [5:0]  fn_q[$];
    logic [16:0] exp;
    logic [16:0] obs;

    always #5 clk = ~clk;

    mips_multicycle_ctrl_if bus ();
    mips_multicycle_ctrl dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    assign obs = {bus.ALUcontrol, bus.ALUSrcA, bus.ALUSrcB, bus.PCSrc, bus.PCEn, bus.IorD,
                  bus.IRWrite, bus.MemWrite, bus.RegDst, bus.MemtoReg, bus.RegWrite, bus.illegal};

    // Expected output vector per state, built from the state/output table.
    function automatic logic [16:0] exp_vec(input int st, input logic [5:0] f, input logic z,
                                            input logic ill, input logic in_rst);
        logic [2:0] alu = 3'b010;
        logic srca = 1'b0;
        logic [1:0] srcb = 2'b00, pcsrc = 2'b00;
        logic pcen = 1'b0, iord = 1'b0, irw = 1'b0, memw = 1'b0;
        logic regdst = 1'b0, m2r = 1'b0, regw = 1'b0, illg = 1'b0;
        case (st)
            S_FETCH:  begin irw = 1'b1; srcb = 2'b01; pcen = 1'b1; end
            S_DECODE: begin srcb = 2'b11; illg = ill; end
            S_MEMADR, S_ADDIEX: begin srca = 1'b1; srcb = 2'b10; end
            S_MEMRD:  iord = 1'b1;
            S_MEMWR:  begin iord = 1'b1; memw = 1'b1; end
            S_MEMWB:  begin regw = 1'b1; m2r = 1'b1; end
            S_EXEC: begin
                srca = 1'b1;
                case (f)
                    6'b100010: alu = 3'b110;
                    6'b100100: alu = 3'b000;
                    6'b100101: alu = 3'b001;
                    6'b101010: alu = 3'b111;
                    default:   alu = 3'b010;
                endcase
            end
            S_ALUWB:  begin regw = 1'b1; regdst = 1'b1; end
            S_ADDIWB: regw = 1'b1;
            S_BRANCH: begin srca = 1'b1; alu = 3'b110; pcsrc = 2'b01; pcen = z; end
            S_JUMP:   begin pcsrc = 2'b10; pcen = 1'b1; end
            default: ;
        endcase
        if (in_rst) begin pcen = 1'b0; irw = 1'b0; memw = 1'b0; regw = 1'b0; end
        return {alu, srca, srcb, pcsrc, pcen, iord, irw, memw, regdst, m2r, regw, illg};
    endfunction

    task automatic test_reset();
        reset_n = 1'b0; bus.Op = 6'b000000; bus.Funct = 6'b100010; bus.zero = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        exp_q.push_back(exp_vec(S_FETCH, 6'd0, 1'b0, 1'b0, 1'b1));
        exp = exp_q.pop_front(); checks++;
        if (obs !== exp) begin errors++; $display("FAIL reset_hold got=%05h want=%05h", obs, exp); end
        reset_n = 1'b1; bus.zero = 1'b0;
        #1;
        exp_q.push_back(exp_vec(S_FETCH, 6'd0, 1'b0, 1'b0, 1'b0));
        exp = exp_q.pop_front(); checks++;
        if (obs !== exp) begin errors++; $display("FAIL reset_release got=%05h want=%05h", obs, exp); end
    endtask

    task automatic test_rtype();
        logic [5:0] functs [5] = '{6'b100010, 6'b100000, 6'b100100, 6'b100101, 6'b101010};
        int n;
        foreach (functs[k]) begin
            bus.Op = 6'b000000; bus.Funct = functs[k];
            exp_q.push_back(exp_vec(S_FETCH,  functs[k], 1'b0, 1'b0, 1'b0));
            exp_q.push_back(exp_vec(S_DECODE, functs[k], 1'b0, 1'b0, 1'b0));
            exp_q.push_back(exp_vec(S_EXEC,   functs[k], 1'b0, 1'b0, 1'b0));
            exp_q.push_back(exp_vec(S_ALUWB,  functs[k], 1'b0, 1'b0, 1'b0));
            exp_q.push_back(exp_vec(S_FETCH,  functs[k], 1'b0, 1'b0, 1'b0));
            n = exp_q.size();
            for (int i = 0; i < n; i++) begin
                if (i > 0) begin @(negedge clk); #1; end
                exp = exp_q.pop_front(); checks++;
                if (obs !== exp) begin
                    errors++;
                    $display("FAIL rtype f=%06b cyc%0d got=%05h want=%05h", functs[k], i, obs, exp);
                end
            end
        end
    endtask

    task automatic test_lw();
        int n;
        bus.Op = 6'b100011; bus.Funct = 6'b000000; bus.zero = 1'b1;
        exp_q.push_back(exp_vec(S_FETCH,  6'd0, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(exp_vec(S_DECODE, 6'd0, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(exp_vec(S_MEMADR, 6'd0, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(exp_vec(S_MEMRD,  6'd0, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(exp_vec(S_MEMWB,  6'd0, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(exp_vec(S_FETCH,  6'd0, 1'b1, 1'b0, 1'b0));
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin @(negedge clk); #1; end
            exp = exp_q.pop_front(); checks++;
            if (obs !== exp) begin errors++; $display("FAIL lw cyc%0d got=%05h want=%05h", i, obs, exp); end
        end
        bus.zero = 1'b0;
    endtask

    task automatic test_beq();
        int n;
        for (int z = 1; z >= 0; z--) begin
            bus.Op = 6'b000100; bus.Funct = 6'b000000; bus.zero = z[0];
            exp_q.push_back(exp_vec(S_FETCH,  6'd0, z[0], 1'b0, 1'b0));
            exp_q.push_back(exp_vec(S_DECODE, 6'd0, z[0], 1'b0, 1'b0));
            exp_q.push_back(exp_vec(S_BRANCH, 6'd0, z[0], 1'b0, 1'b0));
            exp_q.push_back(exp_vec(S_FETCH,  6'd0, z[0], 1'b0, 1'b0));
            n = exp_q.size();
            for (int i = 0; i < n; i++) begin
                if (i > 0) begin @(negedge clk); #1; end
                exp = exp_q.pop_front(); checks++;
                if (obs !== exp) begin
                    errors++;
                    $display("FAIL beq z=%0d cyc%0d got=%05h want=%05h", z, i, obs, exp);
                end
            end
        end
        bus.zero = 1'b0;
    endtask

    task automatic test_illegal();
        logic [5:0] ops [2] = '{6'b000000, 6'b111111};
        int n;
        foreach (ops[k]) begin
            bus.Op = ops[k]; bus.Funct = 6'b000000;
            exp_q.push_back(exp_vec(S_FETCH,  6'd0, 1'b0, 1'b0, 1'b0));
            exp_q.push_back(exp_vec(S_DECODE, 6'd0, 1'b0, 1'b1, 1'b0));
            exp_q.push_back(exp_vec(S_FETCH,  6'd0, 1'b0, 1'b0, 1'b0));
            n = exp_q.size();
            for (int i = 0; i < n; i++) begin
                if (i > 0) begin @(negedge clk); #1; end
                exp = exp_q.pop_front(); checks++;
                if (obs !== exp) begin
                    errors++;
                    $display("FAIL illegal op=%06b cyc%0d got=%05h want=%05h", ops[k], i, obs, exp);
                end
            end
        end
    endtask

    task automatic test_sw_reset();
        int n;
        bus.Op = 6'b101011; bus.Funct = 6'b000000;
        exp_q.push_back(exp_vec(S_FETCH,  6'd0, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(exp_vec(S_DECODE, 6'd0, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(exp_vec(S_MEMADR, 6'd0, 1'b0, 1'b0, 1'b0));
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin @(negedge clk); #1; end
            exp = exp_q.pop_front(); checks++;
            if (obs !== exp) begin errors++; $display("FAIL sw_pre cyc%0d got=%05h want=%05h", i, obs, exp); end
        end
        reset_n = 1'b0;
        #1;
        exp_q.push_back(exp_vec(S_FETCH, 6'd0, 1'b0, 1'b0, 1'b1));
        exp = exp_q.pop_front(); checks++;
        if (obs !== exp) begin errors++; $display("FAIL sw_async_reset got=%05h want=%05h", obs, exp); end
        @(negedge clk); #1;
        exp_q.push_back(exp_vec(S_FETCH, 6'd0, 1'b0, 1'b0, 1'b1));
        exp = exp_q.pop_front(); checks++;
        if (obs !== exp) begin errors++; $display("FAIL sw_reset_held got=%05h want=%05h", obs, exp); end
        reset_n = 1'b1;
        #1;
        exp_q.push_back(exp_vec(S_FETCH,  6'd0, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(exp_vec(S_DECODE, 6'd0, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(exp_vec(S_MEMADR, 6'd0, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(exp_vec(S_MEMWR,  6'd0, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(exp_vec(S_FETCH,  6'd0, 1'b0, 1'b0, 1'b0));
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin @(negedge clk); #1; end
            exp = exp_q.pop_front(); checks++;
            if (obs !== exp) begin errors++; $display("FAIL sw_full cyc%0d got=%05h want=%05h", i, obs, exp); end
        end
    endtask

    task automatic test_addi();
        int n;
        bus.Op = 6'b001000; bus.Funct = 6'b000000;
        exp_q.push_back(exp_vec(S_FETCH, 6'd0, 1'b0, 1'b0, 1'b0));
`ifdef MULTICYCLE_ADDI_EN
        exp_q.push_back(exp_vec(S_DECODE, 6'd0, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(exp_vec(S_ADDIEX, 6'd0, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(exp_vec(S_ADDIWB, 6'd0, 1'b0, 1'b0, 1'b0));
`else
        exp_q.push_back(exp_vec(S_DECODE, 6'd0, 1'b0, 1'b1, 1'b0));
`endif
        exp_q.push_back(exp_vec(S_FETCH, 6'd0, 1'b0, 1'b0, 1'b0));
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin @(negedge clk); #1; end
            exp = exp_q.pop_front(); checks++;
            if (obs !== exp) begin errors++; $display("FAIL addi cyc%0d got=%05h want=%05h", i, obs, exp); end
        end
    endtask

    task automatic test_back_to_back();
        int n;
        // lw, j, R-type slt, then the FETCH of the next instruction
        int lw_st [4] = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMRD};
        int j_st  [3] = '{S_FETCH, S_DECODE, S_JUMP};
        int r_st  [4] = '{S_FETCH, S_DECODE, S_EXEC, S_ALUWB};
        foreach (lw_st[k]) begin
            exp_q.push_back(exp_vec(lw_st[k], 6'd0, 1'b0, 1'b0, 1'b0));
            op_q.push_back(6'b100011); fn_q.push_back(6'd0);
        end
        exp_q.push_back(exp_vec(S_MEMWB, 6'd0, 1'b0, 1'b0, 1'b0));
        op_q.push_back(6'b100011); fn_q.push_back(6'd0);
        foreach (j_st[k]) begin
            exp_q.push_back(exp_vec(j_st[k], 6'd0, 1'b0, 1'b0, 1'b0));
            op_q.push_back(6'b000010); fn_q.push_back(6'd0);
        end
        foreach (r_st[k]) begin
            exp_q.push_back(exp_vec(r_st[k], 6'b101010, 1'b0, 1'b0, 1'b0));
            op_q.push_back(6'b000000); fn_q.push_back(6'b101010);
        end
        exp_q.push_back(exp_vec(S_FETCH, 6'd0, 1'b0, 1'b0, 1'b0));
        op_q.push_back(6'b000000); fn_q.push_back(6'b101010);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            bus.Op = op_q.pop_front(); bus.Funct = fn_q.pop_front();
            #1;
            exp = exp_q.pop_front(); checks++;
            if (obs !== exp) begin errors++; $display("FAIL b2b cyc%0d got=%05h want=%05h", i, obs, exp); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_rtype();
        test_lw();
        test_beq();
        test_illegal();
        test_sw_reset();
        test_addi();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
